assoc_cache: RTL and testbench
==============================

ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter DW, default 16: data word width in bits.
REQ-002 Parameter AW, default 16: word address width in bits.
REQ-003 Parameter SETS, default 8: number of sets; power of two, 2..256; IW = log2(SETS), TW = AW-IW.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 DataIn  input  DW  store data from pipeline.
REQ-007 write  input  1  store request.
REQ-008 read  input  1  load request.
REQ-009 MemAddress  input  AW  word address of the access.
REQ-010 DataOutMainModule  output  DW  load data.
REQ-011 StallPipeline  output  1  high while the current access cannot complete.
REQ-012 mem_req  output  1  backing-memory request.
REQ-013 mem_we  output  1  1 = writeback, 0 = line fill.
REQ-014 mem_addr  output  AW  backing-memory word address.
REQ-015 mem_wdata  output  DW  writeback data.
REQ-016 mem_rdata  input  DW  fill data, valid with mem_ack.
REQ-017 mem_ack  input  1  one-cycle completion pulse for the current mem_req.

Function
REQ-018 Organisation: 2-way set-associative, one-word lines, write-back, write-allocate; per way per set: valid, dirty, TW-bit tag, DW-bit data; per set: one LRU bit naming the least-recently-used way.
REQ-019 Index = MemAddress[IW-1:0]; tag = MemAddress[AW-1:IW].
REQ-020 Access active when read or write is high; when both are high the access is a write.
REQ-021 Hit = valid and tag match in either way; evaluated combinationally in IDLE.
REQ-022 Read hit: DataOutMainModule = hit-way data in the same cycle, StallPipeline 0; LRU bit points to the other way at the next edge.
REQ-023 Write hit: at the next edge, data written, dirty set, LRU updated; StallPipeline 0.
REQ-024 DataOutMainModule is 0 whenever the access is not a read hit in IDLE.
REQ-025 Miss: StallPipeline goes high combinationally in the same cycle and stays high until the access hits; the requester holds read/write/MemAddress/DataIn stable while stalled.
REQ-026 Victim: first invalid way (way 0 preferred), else the way named by the LRU bit.
REQ-027 FSM states IDLE, WBACK, FILL; IDLE->WBACK on miss with valid and dirty victim; IDLE->FILL on miss otherwise; WBACK->FILL on mem_ack; FILL->IDLE on mem_ack.
REQ-028 WBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index}, mem_wdata=victim data.
REQ-029 FILL: mem_req=1, mem_we=0, mem_addr=MemAddress; on mem_ack: victim way gets mem_rdata and the new tag, valid=1, dirty=0.
REQ-030 mem_req, mem_we, mem_addr and mem_wdata are held stable from entry to the state until mem_ack, regardless of ack delay; mem_req is 0 in IDLE.
REQ-031 After the FILL->IDLE transition the held access re-evaluates as a hit the following cycle: one-cycle hit path; no data bypass from fill.
REQ-032 mem_ack received in IDLE is ignored.

Reset
REQ-033 While rst=0 at a rising edge: all valid, dirty and LRU bits cleared, FSM to IDLE; tag/data arrays need not be cleared.
REQ-034 During reset and the cycle after: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; DataOutMainModule=0; StallPipeline follows REQ-025 from the first IDLE cycle.
REQ-035 Reset during WBACK or FILL aborts the transaction; pending dirty data is discarded.

Verification (DW=16, AW=16, SETS=8)
REQ-036 Cold read: after reset, read 0x0001 -> StallPipeline=1 and FILL with mem_addr=0x0001, mem_we=0; ack with mem_rdata=0x1234 -> next cycle StallPipeline=0, DataOutMainModule=0x1234.
REQ-037 Write hit: write 0x0055 to 0x0001 -> no stall, no mem_req; read 0x0001 -> 0x0055, no stall.
REQ-038 Dirty eviction: fill 0x0009, then access 0x0001, then write 0x0055 to 0x0001, then access 0x0011 (all set 1) -> WBACK with mem_addr=0x0009 only if that way is dirty, else FILL of 0x0011 into the LRU way; repeat with 0x0001 as LRU -> WBACK mem_addr=0x0001, mem_wdata=0x0055, then FILL 0x0011.
REQ-039 Slow memory: mem_ack delayed 5 cycles -> mem_req, mem_addr and StallPipeline held constant for all 5 cycles.
REQ-040 Reset mid-fill: rst=0 in FILL -> mem_req=0 the next cycle; a later read of the same address misses again.
REQ-041 Read and write both high on 0x0002 with DataIn=0xBEEF -> treated as write; a subsequent read returns 0xBEEF.

Source files
------------

// File: rtl/assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : assoc_cache
// Purpose  : 2-way set-associative, write-back / write-allocate data cache
//            with one-word lines, per-set LRU bit and a simple backing-memory
//            handshake (one request at a time, completed by a mem_ack pulse).
// Revision : 1.0  initial release
// ============================================================================
module assoc_cache #(
  parameter int DW   = 16,
  parameter int AW   = 16,
  parameter int SETS = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] DataIn,
  input  logic          write,
  input  logic          read,
  input  logic [AW-1:0] MemAddress,
  output logic [DW-1:0] DataOutMainModule,
  output logic          StallPipeline,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int IW = $clog2(SETS);
  localparam int TW = AW - IW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WBACK = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Per-set storage: bit/entry [w] belongs to way w.
  logic [1:0]    valid_q [SETS];
  logic [1:0]    dirty_q [SETS];
  logic [SETS-1:0] lru_q;
  logic [TW-1:0] tag_q   [SETS][2];
  logic [DW-1:0] data_q  [SETS][2];

  // Registered memory-side outputs so they stay put for the whole transaction.
  logic          mem_req_q,   mem_req_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          victim_q,    victim_d;

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          access;
  logic          hit0, hit1, hit;
  logic          hit_way;
  logic          victim_way;
  logic          victim_dirty;
  logic          do_hit;
  logic          do_fill;

  assign idx    = MemAddress[IW-1:0];
  assign tag    = MemAddress[AW-1:IW];
  assign access = read | write;

  assign hit0    = valid_q[idx][0] && (tag_q[idx][0] == tag);
  assign hit1    = valid_q[idx][1] && (tag_q[idx][1] == tag);
  assign hit     = hit0 | hit1;
  assign hit_way = ~hit0;

  // Fill an empty way first (way 0 preferred); otherwise evict the LRU way.
  assign victim_way   = !valid_q[idx][0] ? 1'b0 :
                        !valid_q[idx][1] ? 1'b1 : lru_q[idx];
  assign victim_dirty = valid_q[idx][victim_way] && dirty_q[idx][victim_way];

  // FSM state register; reset abandons any in-flight memory transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      victim_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      victim_q    <= victim_d;
    end
  end

  // Next-state logic and the memory request that goes with each new state.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    victim_d    = victim_q;
    do_hit      = 1'b0;
    do_fill     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access) begin
          if (hit) begin
            do_hit = 1'b1;
          end else begin
            victim_d  = victim_way;
            mem_req_d = 1'b1;
            if (victim_dirty) begin
              state_d     = S_WBACK;
              mem_we_d    = 1'b1;
              mem_addr_d  = {tag_q[idx][victim_way], idx};
              mem_wdata_d = data_q[idx][victim_way];
            end else begin
              state_d    = S_FILL;
              mem_we_d   = 1'b0;
              mem_addr_d = MemAddress;
            end
          end
        end
      end
      S_WBACK: begin
        if (mem_ack) begin
          state_d    = S_FILL;
          mem_we_d   = 1'b0;
          mem_addr_d = MemAddress;
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          do_fill   = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // Status bits: hits refresh LRU (and dirty on stores), fills validate a line.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
      lru_q <= '0;
    end else begin
      if (do_hit) begin
        lru_q[idx] <= ~hit_way;
        if (write) begin
          dirty_q[idx][hit_way] <= 1'b1;
        end
      end
      if (do_fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits make their content moot.
  always_ff @(posedge clk) begin
    if (do_hit && write) begin
      data_q[idx][hit_way] <= DataIn;
    end
    if (do_fill) begin
      data_q[idx][victim_q] <= mem_rdata;
      tag_q[idx][victim_q]  <= tag;
    end
  end

  // Outputs are forced quiet while reset is held so nothing leaks before the edge.
  assign StallPipeline     = (state_q != S_IDLE) || (access && !hit);
  assign DataOutMainModule = (rst && state_q == S_IDLE && read && !write && hit) ?
                             data_q[idx][hit_way] : '0;
  assign mem_req   = rst & mem_req_q;
  assign mem_we    = rst & mem_we_q;
  assign mem_addr  = rst ? mem_addr_q  : '0;
  assign mem_wdata = rst ? mem_wdata_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_assoc_cache
// Purpose  : directed scoreboard bench for assoc_cache (DW=16, AW=16, SETS=8)
// Revision : 1.0  initial release
// ============================================================================
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] DataIn;
  logic        write;
  logic        read;
  logic [15:0] MemAddress;
  logic [15:0] DataOutMainModule;
  logic        StallPipeline;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  assoc_cache #(.DW(16), .AW(16), .SETS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .DataIn            (DataIn),
    .write             (write),
    .read              (read),
    .MemAddress        (MemAddress),
    .DataOutMainModule (DataOutMainModule),
    .StallPipeline     (StallPipeline),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  int          vectors    = 0;
  int          miscompares = 0;
  logic [15:0] bmem [logic [15:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_mem(input bit we, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.is_mem = 1'b1; e.we = we; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic exp_acc(input logic [15:0] d);
    exp_t e;
    e.is_mem = 1'b0; e.we = 1'b0; e.addr = '0; e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: new memory transactions and completed accesses pop the scoreboard.
  logic        prev_req  = 1'b0;
  logic        prev_we   = 1'b0;
  logic [15:0] prev_addr = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (mem_req && (!prev_req || mem_we != prev_we || mem_addr != prev_addr)) begin
        if (sb.size() == 0) begin
          chk("unexpected_mem_req", {mem_we, mem_addr}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("event_is_mem", 1'b1, e.is_mem);
          chk("mem_we", mem_we, e.we);
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) chk("mem_wdata", mem_wdata, e.data);
        end
      end
      if ((read || write) && !StallPipeline) begin
        if (sb.size() == 0) begin
          chk("unexpected_completion", DataOutMainModule, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("event_is_access", 1'b0, e.is_mem);
          chk("dout", DataOutMainModule, e.data);
        end
      end
    end
    prev_req  = mem_req;
    prev_we   = mem_we;
    prev_addr = mem_addr;
  end

  // Drive one access and play the memory side until the cache stops stalling.
  task automatic access(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input bit exp_miss, input int delay);
    int          wc;
    bit          done;
    logic [15:0] ha;
    logic        hw;
    @(posedge clk); #1;
    read = rd; write = wr; MemAddress = a; DataIn = d;
    wc = 0; done = 1'b0; ha = '0; hw = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (cyc == 0) begin
        chk("first_cycle_stall", StallPipeline, exp_miss);
        if (exp_miss) chk("dout_zero_on_miss", DataOutMainModule, 16'h0);
      end
      if (!StallPipeline) begin
        done = 1'b1;
        break;
      end
      if (mem_req) begin
        if (wc == 0) begin
          ha = mem_addr; hw = mem_we;
        end else begin
          chk("hold_mem_addr", mem_addr, ha);
          chk("hold_mem_we", mem_we, hw);
        end
        wc++;
        if (wc > delay) begin
          mem_ack   = 1'b1;
          mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : 16'h0;
          if (mem_we) bmem[mem_addr] = mem_wdata;
          wc = 0;
        end
      end else if (wc > 0) begin
        chk("hold_mem_req", mem_req, 1'b1);
        wc = 0;
      end
    end
    if (!done) chk("access_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b0; read = 1'b0; write = 1'b0; MemAddress = '0; DataIn = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    bmem[16'h0001] = 16'h1234; bmem[16'h0009] = 16'h9999;
    bmem[16'h0011] = 16'h1111; bmem[16'h0019] = 16'h1919;
    bmem[16'h0002] = 16'h2222; bmem[16'h0003] = 16'h3333;

    // Reset values, during reset and in the first cycle after it.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_mem_wdata", mem_wdata, 16'h0);
    chk("rst_dout", DataOutMainModule, 16'h0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_mem_req", mem_req, 1'b0);
    chk("post_rst_mem_addr", mem_addr, 16'h0);
    chk("post_rst_mem_wdata", mem_wdata, 16'h0);
    chk("post_rst_dout", DataOutMainModule, 16'h0);
    chk("post_rst_stall", StallPipeline, 1'b0);

    // Cold read miss then fill.
    exp_mem(1'b0, 16'h0001, 16'h0); exp_acc(16'h1234);
    access(1, 0, 16'h0001, 16'h0000, 1, 0);
    // Write hit, then read it back.
    exp_acc(16'h0000);
    access(0, 1, 16'h0001, 16'h0055, 0, 0);
    exp_acc(16'h0055);
    access(1, 0, 16'h0001, 16'h0000, 0, 0);
    // Same set: 0x0009 into the empty way, refresh 0x0001, dirty it again.
    exp_mem(1'b0, 16'h0009, 16'h0); exp_acc(16'h9999);
    access(1, 0, 16'h0009, 16'h0000, 1, 0);
    exp_acc(16'h0055);
    access(1, 0, 16'h0001, 16'h0000, 0, 0);
    exp_acc(16'h0000);
    access(0, 1, 16'h0001, 16'h0055, 0, 0);
    // LRU way holds clean 0x0009: straight fill, no writeback.
    exp_mem(1'b0, 16'h0011, 16'h0); exp_acc(16'h1111);
    access(1, 0, 16'h0011, 16'h0000, 1, 0);
    exp_acc(16'h0055);
    access(1, 0, 16'h0001, 16'h0000, 0, 0);
    // Slow memory on a clean eviction of 0x0011.
    exp_mem(1'b0, 16'h0019, 16'h0); exp_acc(16'h1919);
    access(1, 0, 16'h0019, 16'h0000, 1, 5);
    // Dirty 0x0001 is now LRU: writeback then fill of 0x0011.
    exp_mem(1'b1, 16'h0001, 16'h0055); exp_mem(1'b0, 16'h0011, 16'h0); exp_acc(16'h1111);
    access(1, 0, 16'h0011, 16'h0000, 1, 2);
    // Refetch of 0x0001 returns the written-back value.
    exp_mem(1'b0, 16'h0001, 16'h0); exp_acc(16'h0055);
    access(1, 0, 16'h0001, 16'h0000, 1, 0);
    // Read and write together act as a write.
    exp_mem(1'b0, 16'h0002, 16'h0); exp_acc(16'h0000);
    access(1, 1, 16'h0002, 16'hBEEF, 1, 0);
    exp_acc(16'hBEEF);
    access(1, 0, 16'h0002, 16'h0000, 0, 0);

    // Reset in the middle of a fill of 0x0003.
    exp_mem(1'b0, 16'h0003, 16'h0);
    @(posedge clk); #1;
    read = 1'b1; MemAddress = 16'h0003;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) begin seen = 1'b1; break; end
    end
    chk("midfill_req_seen", seen, 1'b1);
    #1 rst = 1'b0; read = 1'b0;
    @(negedge clk);
    chk("midfill_rst_req", mem_req, 1'b0);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midfill_after_req", mem_req, 1'b0);
    chk("midfill_after_stall", StallPipeline, 1'b0);
    exp_mem(1'b0, 16'h0003, 16'h0); exp_acc(16'h3333);
    access(1, 0, 16'h0003, 16'h0000, 1, 0);
    // Dirty 0xBEEF was dropped by reset; memory copy comes back.
    exp_mem(1'b0, 16'h0002, 16'h0); exp_acc(16'h2222);
    access(1, 0, 16'h0002, 16'h0000, 1, 0);

    repeat (3) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("missing_event", 32'hFFFF_FFFF, {15'd0, e.is_mem, e.addr});
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
